// File: rtl/in_switch.sv
// in_switch: routes one AXI-Stream input to one of three output ports per
// packet, with a 2-entry skid buffer so the input tready is fully registered.
// Route 3 discards the packet while still accepting its beats.
//
//   state | meaning
//   IDLE  | awaiting first beat of a packet; sel is sampled on that beat
//   BUSY  | mid-packet; beats follow the route latched on the first beat
module in_switch #(
  parameter int DWIDTH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic              weight_switch,
  input  logic [1:0]        sel,
  output logic [DWIDTH-1:0] m_axis_tdata_0,
  output logic              m_axis_tvalid_0,
  input  logic              m_axis_tready_0,
  output logic              m_axis_tlast_0,
  output logic [DWIDTH-1:0] m_axis_tdata_1,
  output logic              m_axis_tvalid_1,
  input  logic              m_axis_tready_1,
  output logic              m_axis_tlast_1,
  output logic [DWIDTH-1:0] m_axis_tdata_2,
  output logic              m_axis_tvalid_2,
  input  logic              m_axis_tready_2,
  output logic              m_axis_tlast_2,
  output logic              weight_switch_out,
  output logic [15:0]       pkt_cnt_0,
  output logic [15:0]       pkt_cnt_1,
  output logic [15:0]       pkt_cnt_2,
  output logic [15:0]       drop_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [1:0]        route_lat;
  logic              tready_r;

  logic              main_valid;
  logic [DWIDTH-1:0] main_data;
  logic              main_last;
  logic              main_ws;
  logic [1:0]        main_route;

  logic              skid_valid;
  logic [DWIDTH-1:0] skid_data;
  logic              skid_last;
  logic              skid_ws;
  logic [1:0]        skid_route;

  logic [15:0]       pkt_cnt_0_r;
  logic [15:0]       pkt_cnt_1_r;
  logic [15:0]       pkt_cnt_2_r;
  logic [15:0]       drop_cnt_r;

  logic              accept;
  logic [1:0]        beat_route;
  logic              store;
  logic              route_ready;
  logic              out_hs;
  logic              main_free;
  logic              skid_valid_nxt;

  // Per-cycle handshake decode and next skid occupancy
  always_comb begin
    accept      = s_axis_tvalid & tready_r;
    beat_route  = (state == IDLE) ? sel : route_lat;
    store       = accept & (beat_route != 2'd3);
    route_ready = 1'b0;
    case (main_route)
      2'd0:    route_ready = m_axis_tready_0;
      2'd1:    route_ready = m_axis_tready_1;
      2'd2:    route_ready = m_axis_tready_2;
      default: route_ready = 1'b0;
    endcase
    out_hs    = main_valid & route_ready;
    main_free = out_hs | ~main_valid;
    // A new beat can only arrive while skid is empty, so whenever main frees
    // up the skid is either drained into main or stays empty.
    skid_valid_nxt = main_free ? 1'b0 : (skid_valid | store);
  end

  // Routing FSM: latch sel on the first beat of each packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      route_lat <= 2'd0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          route_lat <= sel;
          state     <= s_axis_tlast ? IDLE : BUSY;
        end
        BUSY: begin
          if (s_axis_tlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Skid buffer: main feeds the outputs, skid catches one beat under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tready_r   <= 1'b0;
      main_valid <= 1'b0;
      main_data  <= '0;
      main_last  <= 1'b0;
      main_ws    <= 1'b0;
      main_route <= 2'd0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
      skid_ws    <= 1'b0;
      skid_route <= 2'd0;
    end else begin
      tready_r   <= ~skid_valid_nxt;
      skid_valid <= skid_valid_nxt;
      if (main_free) begin
        if (skid_valid) begin
          main_valid <= 1'b1;
          main_data  <= skid_data;
          main_last  <= skid_last;
          main_ws    <= skid_ws;
          main_route <= skid_route;
        end else if (store) begin
          main_valid <= 1'b1;
          main_data  <= s_axis_tdata;
          main_last  <= s_axis_tlast;
          main_ws    <= weight_switch;
          main_route <= beat_route;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (store) begin
        skid_data  <= s_axis_tdata;
        skid_last  <= s_axis_tlast;
        skid_ws    <= weight_switch;
        skid_route <= beat_route;
      end
    end
  end

  // Packet counters: delivered packets per port, dropped packets on route 3
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_0_r <= 16'd0;
      pkt_cnt_1_r <= 16'd0;
      pkt_cnt_2_r <= 16'd0;
      drop_cnt_r  <= 16'd0;
    end else begin
      if (out_hs && main_last) begin
        case (main_route)
          2'd0:    pkt_cnt_0_r <= pkt_cnt_0_r + 16'd1;
          2'd1:    pkt_cnt_1_r <= pkt_cnt_1_r + 16'd1;
          2'd2:    pkt_cnt_2_r <= pkt_cnt_2_r + 16'd1;
          default: ;
        endcase
      end
      if (accept && (beat_route == 2'd3) && s_axis_tlast)
        drop_cnt_r <= drop_cnt_r + 16'd1;
    end
  end

  assign s_axis_tready     = tready_r;
  assign m_axis_tdata_0    = main_data;
  assign m_axis_tdata_1    = main_data;
  assign m_axis_tdata_2    = main_data;
  assign m_axis_tlast_0    = main_last;
  assign m_axis_tlast_1    = main_last;
  assign m_axis_tlast_2    = main_last;
  assign m_axis_tvalid_0   = main_valid & (main_route == 2'd0);
  assign m_axis_tvalid_1   = main_valid & (main_route == 2'd1);
  assign m_axis_tvalid_2   = main_valid & (main_route == 2'd2);
  assign weight_switch_out = main_ws;
  assign pkt_cnt_0         = pkt_cnt_0_r;
  assign pkt_cnt_1         = pkt_cnt_1_r;
  assign pkt_cnt_2         = pkt_cnt_2_r;
  assign drop_cnt          = drop_cnt_r;

endmodule
